// File: rtl/dendritic_tree.sv
// Multi-branch dendritic model: basal compartment plus NBR apical branches, each with a
// leaky Ca2+ depot and plateau/refractory FSM, feeding a windowed BAC coincidence detector.
module dendritic_tree #(
  parameter int WIDTH        = 18,
  parameter int FRAC         = 14,
  parameter int NBR          = 4,
  parameter int TAU_SHIFT    = 4,
  parameter int HYST         = 1024,
  parameter int PLATEAU_MIN  = 8,
  parameter int REFRAC       = 16,
  parameter int BAC_WINDOW   = 12,
  parameter int APICAL_SHIFT = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clk_en,
  input  logic [WIDTH-1:0]           basal_input,
  input  logic [NBR*WIDTH-1:0]       apical_input,
  input  logic [WIDTH-1:0]           apical_gain,
  input  logic [WIDTH-1:0]           ca_threshold,
  input  logic [WIDTH-1:0]           basal_threshold,
  output logic [WIDTH-1:0]           dendritic_output,
  output logic [NBR-1:0]             ca_spike_active,
  output logic [$clog2(NBR+1)-1:0]   plateau_count,
  output logic                       bac_active,
  output logic                       bac_pulse
);

  localparam int XW      = 2 * WIDTH;
  localparam int PCW     = $clog2(NBR + 1);
  localparam int CNT_MAX = (REFRAC > PLATEAU_MIN) ? REFRAC : PLATEAU_MIN;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int WW      = $clog2(BAC_WINDOW + 1);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] PLATEAU    = 2'd1;
  localparam logic [1:0] REFRACTORY = 2'd2;

  // Clamp a wide signed intermediate into the WIDTH-bit signed range.
  function automatic logic signed [WIDTH-1:0] sat(input logic signed [XW-1:0] v);
    logic signed [XW-1:0] hi;
    logic signed [XW-1:0] lo;
    hi = XW'((2 ** (WIDTH - 1)) - 1);
    lo = -hi - XW'(1);
    if (v > hi) begin
      return hi[WIDTH-1:0];
    end else if (v < lo) begin
      return lo[WIDTH-1:0];
    end else begin
      return v[WIDTH-1:0];
    end
  endfunction

  function automatic logic signed [XW-1:0] ext(input logic [WIDTH-1:0] v);
    return XW'($signed(v));
  endfunction

  logic signed [WIDTH-1:0] depot_r [NBR];
  logic signed [WIDTH-1:0] depot_s [NBR];
  logic [1:0]              state_r [NBR];
  logic [1:0]              state_s [NBR];
  logic [CW-1:0]           cnt_r   [NBR];
  logic [CW-1:0]           cnt_s   [NBR];
  logic [WW-1:0]           win_r;
  logic [WW-1:0]           win_s;
  logic [NBR-1:0]          flags_s;
  logic [PCW-1:0]          count_s;
  logic signed [XW-1:0]    psum_s;
  logic                    hit_s;
  logic                    bac_s;
  logic signed [WIDTH-1:0] base_s;
  logic signed [XW-1:0]    base_w_s;
  logic signed [WIDTH-1:0] out_s;

  // Per-branch depot update and plateau FSM, judged against the freshly updated depot.
  always_comb begin : branch_next
    logic signed [XW-1:0] prod;
    logic signed [XW-1:0] drive;
    logic signed [XW-1:0] cur;
    logic signed [XW-1:0] nxt;
    logic signed [XW-1:0] thr;
    logic signed [XW-1:0] exit_lvl;
    prod     = {XW{1'b0}};
    drive    = {XW{1'b0}};
    cur      = {XW{1'b0}};
    nxt      = {XW{1'b0}};
    thr      = ext(ca_threshold);
    exit_lvl = thr - XW'(HYST);
    psum_s   = {XW{1'b0}};
    flags_s  = {NBR{1'b0}};
    count_s  = {PCW{1'b0}};
    for (int i = 0; i < NBR; i++) begin
      prod       = ext(apical_input[i*WIDTH +: WIDTH]) * ext(apical_gain);
      drive      = ext(sat(prod >>> FRAC));
      cur        = ext(depot_r[i]);
      depot_s[i] = sat(cur + ((drive - cur) >>> TAU_SHIFT));
      nxt        = ext(depot_s[i]);
      state_s[i] = state_r[i];
      cnt_s[i]   = cnt_r[i];
      case (state_r[i])
        IDLE: begin
          if (nxt > thr) begin
            state_s[i] = PLATEAU;
            cnt_s[i]   = CW'(PLATEAU_MIN);
          end else begin
            state_s[i] = IDLE;
          end
        end
        PLATEAU: begin
          if ((cnt_r[i] == {CW{1'b0}}) && (nxt < exit_lvl)) begin
            state_s[i] = REFRACTORY;
            cnt_s[i]   = CW'(REFRAC);
          end else if (cnt_r[i] != {CW{1'b0}}) begin
            cnt_s[i] = cnt_r[i] - CW'(1);
          end else begin
            cnt_s[i] = cnt_r[i];
          end
        end
        REFRACTORY: begin
          // Leaving on the count that reaches zero lets re-entry happen on the next tick.
          if (cnt_r[i] <= CW'(1)) begin
            state_s[i] = IDLE;
            cnt_s[i]   = {CW{1'b0}};
          end else begin
            cnt_s[i] = cnt_r[i] - CW'(1);
          end
        end
        default: begin
          state_s[i] = IDLE;
          cnt_s[i]   = {CW{1'b0}};
        end
      endcase
      flags_s[i] = (state_s[i] == PLATEAU);
      if (flags_s[i]) begin
        psum_s  = psum_s + nxt;
        count_s = count_s + PCW'(1);
      end else begin
        psum_s  = psum_s;
        count_s = count_s;
      end
    end
  end

  // Basal eligibility window, BAC coincidence and the combined output value.
  always_comb begin
    hit_s = $signed(basal_input) > $signed(basal_threshold);
    if (hit_s) begin
      win_s = WW'(BAC_WINDOW);
    end else if (win_r != {WW{1'b0}}) begin
      win_s = win_r - WW'(1);
    end else begin
      win_s = win_r;
    end
    bac_s    = (hit_s || (win_r != {WW{1'b0}})) && (|flags_s);
    base_s   = sat(ext(basal_input) + (psum_s >>> APICAL_SHIFT));
    base_w_s = ext(base_s);
    if (bac_s) begin
      out_s = sat(base_w_s + (base_w_s >>> 1));
    end else begin
      out_s = base_s;
    end
  end

  // State and output registers; everything holds between clk_en ticks except the pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NBR; i++) begin
        depot_r[i] <= {WIDTH{1'b0}};
        state_r[i] <= IDLE;
        cnt_r[i]   <= {CW{1'b0}};
      end
      win_r            <= {WW{1'b0}};
      dendritic_output <= {WIDTH{1'b0}};
      ca_spike_active  <= {NBR{1'b0}};
      plateau_count    <= {PCW{1'b0}};
      bac_active       <= 1'b0;
      bac_pulse        <= 1'b0;
    end else if (clk_en) begin
      for (int i = 0; i < NBR; i++) begin
        depot_r[i] <= depot_s[i];
        state_r[i] <= state_s[i];
        cnt_r[i]   <= cnt_s[i];
      end
      win_r            <= win_s;
      dendritic_output <= out_s;
      ca_spike_active  <= flags_s;
      plateau_count    <= count_s;
      bac_active       <= bac_s;
      bac_pulse        <= bac_s && !bac_active;
    end else begin
      bac_pulse <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dendritic_tree.sv
// Scoreboard bench for dendritic_tree: a reference model queues the expected outputs per
// clock, a monitor compares them, and directed checks cover the timing and BAC scenarios.
module tb_dendritic_tree;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic signed [17:0] basal;
  logic signed [17:0] ap [4];
  logic signed [17:0] gain;
  logic signed [17:0] cthr;
  logic signed [17:0] bthr;
  logic [71:0] apical_input;
  logic [17:0] dendritic_output;
  logic [3:0]  ca_spike_active;
  logic [2:0]  plateau_count;
  logic        bac_active;
  logic        bac_pulse;

  assign apical_input = {ap[3], ap[2], ap[1], ap[0]};

  dendritic_tree dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .basal_input(basal), .apical_input(apical_input), .apical_gain(gain),
    .ca_threshold(cthr), .basal_threshold(bthr),
    .dendritic_output(dendritic_output), .ca_spike_active(ca_spike_active),
    .plateau_count(plateau_count), .bac_active(bac_active), .bac_pulse(bac_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] out;
    logic [3:0]  flags;
    logic [2:0]  count;
    logic        bac;
    logic        pulse;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input longint act, input longint lo, input longint hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Reference model state
  longint m_depot [4];
  int     m_state [4];
  int     m_cnt   [4];
  int     m_win = 0;
  bit     m_bac = 1'b0;
  exp_t   m_exp = '{18'd0, 4'd0, 3'd0, 1'b0, 1'b0};

  function automatic longint msat(input longint v);
    if (v > 131071) return 131071;
    if (v < -131072) return -131072;
    return v;
  endfunction

  task automatic model_step(input bit en, input bit r);
    longint s;
    longint psum;
    longint base;
    longint outv;
    bit     hit;
    bit     bacn;
    int     cnt;
    if (r) begin
      for (int i = 0; i < 4; i++) begin
        m_depot[i] = 0; m_state[i] = 0; m_cnt[i] = 0;
      end
      m_win = 0; m_bac = 1'b0;
      m_exp = '{18'd0, 4'd0, 3'd0, 1'b0, 1'b0};
    end else if (en) begin
      hit  = (basal > bthr);
      psum = 0; cnt = 0;
      m_exp.flags = 4'd0;
      for (int i = 0; i < 4; i++) begin
        s = msat((longint'(ap[i]) * longint'(gain)) >>> 14);
        m_depot[i] = msat(m_depot[i] + ((s - m_depot[i]) >>> 4));
        if (m_state[i] == 0) begin
          if (m_depot[i] > longint'(cthr)) begin m_state[i] = 1; m_cnt[i] = 8; end
        end else if (m_state[i] == 1) begin
          if (m_cnt[i] == 0 && m_depot[i] < longint'(cthr) - 1024) begin
            m_state[i] = 2; m_cnt[i] = 16;
          end else if (m_cnt[i] != 0) m_cnt[i]--;
        end else begin
          if (m_cnt[i] <= 1) begin m_state[i] = 0; m_cnt[i] = 0; end
          else m_cnt[i]--;
        end
        if (m_state[i] == 1) begin
          m_exp.flags[i] = 1'b1; psum += m_depot[i]; cnt++;
        end
      end
      bacn = (hit || m_win != 0) && (cnt != 0);
      m_exp.pulse = bacn && !m_bac;
      m_bac = bacn;
      m_win = hit ? 12 : ((m_win != 0) ? m_win - 1 : 0);
      base = msat(longint'(basal) + (psum >>> 2));
      outv = bacn ? msat(base + (base >>> 1)) : base;
      m_exp.out   = outv[17:0];
      m_exp.count = cnt[2:0];
      m_exp.bac   = bacn;
    end else begin
      m_exp.pulse = 1'b0;
    end
    q.push_back(m_exp);
  endtask

  // One clock: drive at the falling edge, queue the expectation, return just after the rising edge.
  task automatic tick(input bit en, input bit r);
    @(negedge clk);
    clk_en = en;
    rst    = r;
    model_step(en, r);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every clock edge that had stimulus yields one queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sb_output", dendritic_output, e.out);
        chk("sb_flags", ca_spike_active, e.flags);
        chk("sb_count", plateau_count, e.count);
        chk("sb_bac", bac_active, e.bac);
        chk("sb_pulse", bac_pulse, e.pulse);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int found;
    int act;
    int bac_cnt;
    int pulse_cnt;
    rst = 1'b1; clk_en = 1'b0;
    basal = 18'sd5000; gain = 18'sd16384; cthr = 18'sd8192; bthr = 18'sd8192;
    for (int i = 0; i < 4; i++) ap[i] = 18'sd3000;

    // Reset with nonzero inputs
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    chk("rst_output", dendritic_output, 0);
    chk("rst_count", plateau_count, 0);
    chk("rst_pulse", bac_pulse, 0);
    repeat (3) tick(1'b0, 1'b0);
    chk("hold_output", dendritic_output, 0);

    // Branch independence
    ap[0] = 18'sd0; ap[1] = 18'sd0; ap[2] = 18'sd12288; ap[3] = 18'sd4096;
    for (int k = 0; k < 40; k++) begin
      tick(1'b1, 1'b0);
      if (k % 5 == 0) tick(1'b0, 1'b0);
    end
    chk("indep_flags", ca_spike_active, 4'b0100);
    chk("indep_count", plateau_count, 1);
    tick(1'b1, 1'b1);
    chk("midplateau_rst_flags", ca_spike_active, 0);

    // Negative drive never triggers a plateau
    for (int i = 0; i < 4; i++) ap[i] = -18'sd16384;
    for (int k = 0; k < 40; k++) tick(1'b1, 1'b0);
    chk("negative_flags", ca_spike_active, 0);

    // Hysteresis, minimum plateau length, refractory
    tick(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) ap[i] = 18'sd0;
    ap[0] = 18'sd16384;
    found = 0;
    for (int k = 0; k < 40; k++) begin
      tick(1'b1, 1'b0);
      if (ca_spike_active[0]) begin found = 1; break; end
    end
    chk("hyst_entry", found, 1);
    ap[0] = 18'sd0;
    act = 0;
    for (int k = 0; k < 40; k++) begin
      tick(1'b1, 1'b0);
      if (ca_spike_active[0]) act++;
      else break;
    end
    chk_range("plateau_len", act, 8, 12);
    ap[0] = 18'sd16384;
    found = 0;
    for (int k = 1; k <= 40; k++) begin
      tick(1'b1, 1'b0);
      if (ca_spike_active[0]) begin found = k; break; end
    end
    chk("reentry_tick", found, 17);

    // Gain scaling
    tick(1'b1, 1'b1);
    ap[0] = 18'sd4096;
    for (int k = 0; k < 100; k++) tick(1'b1, 1'b0);
    chk("gain_low_flags", ca_spike_active, 0);
    gain = 18'sd40960;
    found = 0;
    for (int k = 0; k < 40; k++) begin
      tick(1'b1, 1'b0);
      if (ca_spike_active[0]) begin found = 1; break; end
    end
    chk("gain_high_entry", found, 1);

    // BAC window: single-tick basal event, clk_en at half rate
    tick(1'b1, 1'b1);
    gain = 18'sd16384; basal = 18'sd0; bthr = 18'sd8192;
    ap[0] = 18'sd0; ap[1] = 18'sd16384;
    found = 0;
    for (int k = 0; k < 40; k++) begin
      tick(1'b1, 1'b0);
      if (ca_spike_active[1]) begin found = 1; break; end
    end
    chk("bac_branch_entry", found, 1);
    basal = 18'sd16384;
    tick(1'b1, 1'b0);
    bac_cnt = int'(bac_active); pulse_cnt = int'(bac_pulse);
    basal = 18'sd0;
    for (int k = 0; k < 30; k++) begin
      tick(1'b0, 1'b0);
      pulse_cnt += int'(bac_pulse);
      tick(1'b1, 1'b0);
      bac_cnt += int'(bac_active);
      pulse_cnt += int'(bac_pulse);
    end
    chk("bac_window_len", bac_cnt, 13);
    chk("bac_pulse_count", pulse_cnt, 1);

    // BAC output scaling and saturation
    tick(1'b1, 1'b1);
    ap[1] = 18'sd0; ap[0] = 18'sd16384;
    basal = 18'sd8192; bthr = 18'sd4096;
    for (int k = 0; k < 200; k++) tick(1'b1, 1'b0);
    chk("bac_level", bac_active, 1);
    chk_range("bac_output", $signed(dendritic_output), 18420, 18440);
    basal = 18'sd0;
    for (int k = 0; k < 14; k++) tick(1'b1, 1'b0);
    chk("nobac_level", bac_active, 0);
    chk_range("nobac_output", $signed(dendritic_output), 4090, 4096);
    basal = 18'sd131071;
    tick(1'b1, 1'b0);
    chk("sat_pos_output", $signed(dendritic_output), 131071);
    basal = -18'sd131072;
    tick(1'b1, 1'b0);
    chk("sat_neg_output", $signed(dendritic_output), -131072);
    tick(1'b1, 1'b1);
    chk("final_rst_output", dendritic_output, 0);
    chk("final_rst_flags", ca_spike_active, 0);

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
